// File: rtl/alarm_responder.sv
// Vault alarm responder: grace-filtered alarm input, blinking siren, acknowledge/hold handling.
// Optional siren-firing counter is built when ALARM_EVENT_COUNT_EN is defined.
module alarm_responder #(
    parameter int GRACE_CYCLES = 3,
    parameter int BLINK_DIV    = 2
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       ack,
    output logic       siren,
    output logic       latched,
    output logic [1:0] state,
    output logic [3:0] event_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_SIREN   = 2'b10,
        ST_HOLD    = 2'b11
    } state_t;

    localparam logic [3:0] GRACE_MAX = 4'(GRACE_CYCLES);
    localparam logic [3:0] BLINK_MAX = 4'(BLINK_DIV);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_grace, w_grace_nxt;
    logic [3:0] r_blink, w_blink_nxt;
    logic       r_siren, w_siren_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grace <= '0;
            r_blink <= '0;
            r_siren <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grace <= w_grace_nxt;
            r_blink <= w_blink_nxt;
            r_siren <= w_siren_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grace_nxt = r_grace;
        w_blink_nxt = r_blink;
        w_siren_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alarm_in) begin
                    w_state_nxt = ST_PENDING;
                    w_grace_nxt = 4'd1;
                end
            end
            ST_PENDING: begin
                if (!alarm_in) begin
                    w_state_nxt = ST_IDLE;
                    w_grace_nxt = '0;
                end else if (r_grace == GRACE_MAX) begin
                    w_state_nxt = ST_SIREN;
                    w_grace_nxt = '0;
                    w_siren_nxt = 1'b1;
                    w_blink_nxt = 4'd1;
                end else begin
                    w_grace_nxt = r_grace + 4'd1;
                end
            end
            ST_SIREN: begin
                // Acknowledge ends the siren; a still-active alarm parks in HOLD instead of re-arming.
                if (ack) begin
                    w_state_nxt = alarm_in ? ST_HOLD : ST_IDLE;
                    w_blink_nxt = '0;
                end else if (r_blink == BLINK_MAX) begin
                    w_siren_nxt = ~r_siren;
                    w_blink_nxt = 4'd1;
                end else begin
                    w_siren_nxt = r_siren;
                    w_blink_nxt = r_blink + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!alarm_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign state   = r_state;
    assign siren   = r_siren;
    assign latched = (r_state == ST_SIREN) || (r_state == ST_HOLD);

`ifdef ALARM_EVENT_COUNT_EN
    logic [3:0] r_event_count;
    logic       w_fire;

    assign w_fire = (r_state == ST_PENDING) && (w_state_nxt == ST_SIREN);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_event_count <= '0;
        end else if (w_fire && (r_event_count != 4'hF)) begin
            r_event_count <= r_event_count + 4'd1;
        end
    end

    assign event_count = r_event_count;
`else
    assign event_count = 4'd0;
`endif

endmodule

// File: tb/tb_alarm_responder.sv
// Self-checking bench for alarm_responder: a cycle model pushes expected outputs to a scoreboard
// queue as each stimulus is driven; entries are popped and compared one step after the clock edge.
module tb_alarm_responder;

    localparam int G = 3;
    localparam int B = 2;
`ifdef ALARM_EVENT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PEND = 2'b01;
    localparam logic [1:0] S_SIR  = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic       sir;
        logic       lat;
        logic [3:0] cnt;
    } exp_t;

    logic       clk_2;
    logic       reset;
    logic       alarm_in;
    logic       ack;
    logic       siren;
    logic       latched;
    logic [1:0] state;
    logic [3:0] event_count;

    exp_t       sb[$];
    int         n_checks;
    int         n_fail;

    logic [1:0] m_state;
    int         m_seen;
    int         m_t;
    int         m_events;
    logic       last_siren;
    logic       obs_pat[6];
    logic       pat[6];

    alarm_responder #(.GRACE_CYCLES(G), .BLINK_DIV(B)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .alarm_in    (alarm_in),
        .ack         (ack),
        .siren       (siren),
        .latched     (latched),
        .state       (state),
        .event_count (event_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_seen   = 0;
        m_t      = 0;
        m_events = 0;
    endtask

    // Reference: siren phase derived from time spent firing, not from a toggle counter.
    task automatic model_step(input logic a, input logic k);
        case (m_state)
            S_IDLE: if (a) begin m_state = S_PEND; m_seen = 1; end
            S_PEND: begin
                if (!a) m_state = S_IDLE;
                else if (m_seen == G) begin
                    m_state = S_SIR;
                    m_t     = 0;
                    if (m_events < 15) m_events++;
                end else m_seen++;
            end
            S_SIR:  if (k) m_state = a ? S_HOLD : S_IDLE; else m_t++;
            default: if (!a) m_state = S_IDLE;
        endcase
    endtask

    task automatic cycle(input logic a, input logic k);
        exp_t e;
        alarm_in = a;
        ack      = k;
        model_step(a, k);
        e.st  = m_state;
        e.sir = (m_state == S_SIR) && (((m_t / B) % 2) == 0);
        e.lat = (m_state == S_SIR) || (m_state == S_HOLD);
        e.cnt = CNT_EN ? 4'(m_events) : 4'd0;
        sb.push_back(e);
        @(posedge clk_2);
        #1;
        e = sb.pop_front();
        check("state",   {2'b00, state},        {2'b00, e.st});
        check("siren",   {3'b000, siren},       {3'b000, e.sir});
        check("latched", {3'b000, latched},     {3'b000, e.lat});
        check("count",   event_count,           e.cnt);
        last_siren = siren;
    endtask

    task automatic fire();
        for (int i = 0; i < G + 1; i++) cycle(1'b1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pat      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        alarm_in = 1'b0;
        ack      = 1'b0;
        reset    = 1'b1;
        model_reset();

        #3;
        check("rst_state",   {2'b00, state},    4'd0);
        check("rst_siren",   {3'b000, siren},   4'd0);
        check("rst_latched", {3'b000, latched}, 4'd0);
        check("rst_count",   event_count,       4'd0);
        @(posedge clk_2);
        #1;
        reset = 1'b0;

        // Glitch: alarm high for two edges, then low; first edge after reset sees IDLE normally.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Fire with ack during PENDING (ignored), then observe six siren cycles.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        obs_pat[0] = last_siren;
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            obs_pat[i] = last_siren;
        end
        for (int i = 0; i < 6; i++) check("siren_pat", {3'b000, obs_pat[i]}, {3'b000, pat[i]});

        // Ack with alarm still active: HOLD ignores ack and never re-fires, clears to IDLE.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        // Ack after alarm has cleared.
        fire();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Asynchronous reset in the middle of SIREN.
        fire();
        cycle(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_state",   {2'b00, state},    4'd0);
        check("arst_siren",   {3'b000, siren},   4'd0);
        check("arst_latched", {3'b000, latched}, 4'd0);
        check("arst_count",   event_count,       4'd0);
        @(posedge clk_2);
        #1;
        reset    = 1'b0;
        alarm_in = 1'b0;

        // Saturation: 17 full fire/ack rounds.
        for (int r = 0; r < 17; r++) begin
            fire();
            cycle(1'b0, 1'b1);
        end
        check("sat_count", event_count, CNT_EN ? 4'd15 : 4'd0);
        check("sb_empty", 4'(sb.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_responder.md
ALARM_RESPONDER -- requirements
Module: alarm_responder

Interface
REQ-001 The block SHALL have parameter GRACE_CYCLES, default 3: consecutive cycles alarm_in must stay high before the siren fires (legal range 1..15).
REQ-002 The block SHALL have parameter BLINK_DIV, default 2: cycles per siren half-period (legal range 1..15).
REQ-003 The block SHALL have port clk_2  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port alarm_in  input  1  alarm request from the vault-door logic; 1 = violation.
REQ-006 The block SHALL have port ack  input  1  manager acknowledge; level-sampled each cycle.
REQ-007 The block SHALL have port siren  output  1  audible/visual siren drive, pulsing while firing.
REQ-008 The block SHALL have port latched  output  1  alarm memory; 1 from siren firing until the alarm clears after acknowledge.
REQ-009 The block SHALL have port state  output  2  current FSM state encoding.
REQ-010 The block SHALL have port event_count  output  4  number of siren firings since reset.

Function
REQ-011 The FSM SHALL have states IDLE=00, PENDING=01, SIREN=10 and HOLD=11.
REQ-012 In IDLE, alarm_in=1 SHALL move to PENDING next cycle with the grace counter loaded to 1.
REQ-013 In PENDING, alarm_in=0 SHALL return to IDLE next cycle with no event counted (glitch rejection).
REQ-014 In PENDING, alarm_in=1 with the grace counter equal to GRACE_CYCLES SHALL move to SIREN; otherwise the grace counter SHALL increment.
REQ-015 With GRACE_CYCLES=3, a constant alarm_in=1 first sampled at edge N SHALL put the FSM in SIREN after edge N+3.
REQ-016 Entering SIREN SHALL increment event_count by 1, saturating at 15 (no wrap).
REQ-017 In SIREN, siren SHALL be 1 on the first cycle and toggle every BLINK_DIV cycles thereafter, regardless of alarm_in.
REQ-018 In SIREN, ack=1 with alarm_in=0 SHALL go to IDLE; ack=1 with alarm_in=1 SHALL go to HOLD.
REQ-019 In HOLD, siren SHALL be 0, latched SHALL stay 1, and alarm_in=0 SHALL go to IDLE next cycle.
REQ-020 In HOLD, ack SHALL be ignored; in HOLD, alarm_in rising again SHALL NOT re-fire without first passing through IDLE.
REQ-021 ack in IDLE or PENDING SHALL have no effect.
REQ-022 latched SHALL be 1 exactly in SIREN and HOLD; siren SHALL be 0 in IDLE, PENDING and HOLD.
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational path from alarm_in or ack to any output.

Reset
REQ-024 Asserting reset at any time, including mid-SIREN, SHALL immediately force state=IDLE, siren=0, latched=0, event_count=0, and clear the grace and blink counters.
REQ-025 After reset deassertion, the first rising edge SHALL evaluate IDLE transitions normally.

Configuration
REQ-026 With macro ALARM_EVENT_COUNT_EN defined, the event counter SHALL be implemented as specified.
REQ-027 Without ALARM_EVENT_COUNT_EN, event_count SHALL be tied to 0, no counter logic SHALL be generated, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset test: reset=1 while in SIREN -> same-cycle (async) state=00, siren=0, latched=0, event_count=0.
REQ-029 Glitch test: alarm_in=1 for 2 cycles then 0 (GRACE_CYCLES=3) -> state 01 then 00, siren never 1, event_count=0.
REQ-030 Fire test: alarm_in held 1 -> state=10 after 3 edges in PENDING; siren pattern 1,1,0,0,1,1 (BLINK_DIV=2); event_count=1.
REQ-031 Ack with alarm active: in SIREN, ack=1 and alarm_in=1 -> state=11, siren=0, latched=1; then alarm_in=0 -> state=00, latched=0.
REQ-032 Ack with alarm cleared: in SIREN, alarm_in=0 then ack=1 -> state=00 next cycle, latched=0.
REQ-033 Saturation test: 17 complete fire/ack cycles -> event_count=15 (with ALARM_EVENT_COUNT_EN), 0 without it.
